// File: rtl/user_reg_master.sv
// ============================================================================
//  Module   : user_reg_master
//  Purpose  : Initiator side of the user register / interrupt interface.
//             Turns host single-DWORD register requests into user register
//             strobes, returns read completions (with a read-ack timeout),
//             and forwards level user interrupts as single MSI requests.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module user_reg_master #(
  parameter int                 ADDR_W         = 20,
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0]  TIMEOUT_DATA   = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // host register request
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  // user register side
  output logic [ADDR_W-1:0] o_user_addr,
  output logic [DATA_W-1:0] o_user_data,
  output logic              o_user_wr_req,
  output logic              o_user_rd_req,
  input  logic              i_user_rd_ack,
  input  logic [DATA_W-1:0] i_user_data,
  // read completion
  output logic              o_cpl_valid,
  input  logic              i_cpl_ready,
  output logic [DATA_W-1:0] o_cpl_data,
  output logic              o_cpl_err,
  // interrupts
  input  logic              i_user_intr_req,
  output logic              o_user_intr_ack,
  output logic              o_msi_req,
  input  logic              i_msi_grant
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, CPL} reg_state_t;
  typedef enum logic [1:0] {IIDLE, IREQ, IACK, IHOLD} intr_state_t;

  reg_state_t  reg_state, reg_state_next;
  intr_state_t intr_state, intr_state_next;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_timeout;

  // The last allowed wait cycle; an ack on this same cycle still wins.
  assign rd_timeout = (rd_cnt == CNT_LAST);

  // Strobes and handshakes are pure state decodes, so they never glitch on inputs.
  assign o_req_ready     = (reg_state == IDLE);
  assign o_user_wr_req   = (reg_state == WR);
  assign o_user_rd_req   = (reg_state == RD_WAIT);
  assign o_cpl_valid     = (reg_state == CPL);
  assign o_msi_req       = (intr_state == IREQ);
  assign o_user_intr_ack = (intr_state == IACK);

  // Register FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) reg_state <= IDLE;
    else          reg_state <= reg_state_next;
  end

  // Register FSM next-state logic
  always_comb begin
    reg_state_next = reg_state;
    case (reg_state)
      IDLE:    if (i_req_valid) reg_state_next = i_req_wr ? WR : RD_WAIT;
      WR:      reg_state_next = IDLE;
      RD_WAIT: if (i_user_rd_ack || rd_timeout) reg_state_next = CPL;
      CPL:     if (i_cpl_ready) reg_state_next = IDLE;
      default: reg_state_next = IDLE;
    endcase
  end

  // Request capture, read-wait counter and completion payload
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_user_addr <= '0;
      o_user_data <= '0;
      o_cpl_data  <= '0;
      o_cpl_err   <= 1'b0;
      rd_cnt      <= '0;
    end else begin
      case (reg_state)
        IDLE: begin
          rd_cnt <= '0;
          if (i_req_valid) begin
            o_user_addr <= i_req_addr;
            o_user_data <= i_req_data;
          end
        end
        RD_WAIT: begin
          rd_cnt <= rd_cnt + CNT_W'(1);
          if (i_user_rd_ack) begin
            o_cpl_data <= i_user_data;
            o_cpl_err  <= 1'b0;
          end else if (rd_timeout) begin
            o_cpl_data <= TIMEOUT_DATA;
            o_cpl_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Interrupt FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) intr_state <= IIDLE;
    else          intr_state <= intr_state_next;
  end

  // Interrupt FSM next-state logic; IHOLD waits for the level to drop so one
  // request level produces exactly one MSI
  always_comb begin
    intr_state_next = intr_state;
    case (intr_state)
      IIDLE:   if (i_user_intr_req) intr_state_next = IREQ;
      IREQ:    if (i_msi_grant) intr_state_next = IACK;
      IACK:    intr_state_next = IHOLD;
      IHOLD:   if (!i_user_intr_req) intr_state_next = IIDLE;
      default: intr_state_next = IIDLE;
    endcase
  end

endmodule

`default_nettype wire
